// File: rtl/dsp48a1_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 MAC sequencer.
// X mux selects M for every beat; Z mux picks 0 on the first beat and P on the rest.
package dsp48a1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // DSP48A1 OPMODE[1:0] is the X mux, OPMODE[3:2] is the Z mux.
    localparam logic [1:0] OPM_X_M    = 2'b01;
    localparam logic [1:0] OPM_Z_ZERO = 2'b00;
    localparam logic [1:0] OPM_Z_P    = 2'b10;

    localparam logic [7:0] OPM_LOAD_DEF = {4'b0000, OPM_Z_ZERO, OPM_X_M};
    localparam logic [7:0] OPM_ACC_DEF  = {4'b0000, OPM_Z_P,    OPM_X_M};

endpackage

// File: rtl/dsp48a1_mac_sequencer_if.sv
// Job/handshake bundle between the operand source and the sequencer, plus the
// slice control outputs (clock enables, OPMODE) and job status.
interface dsp48a1_mac_sequencer_if #(
    parameter int LEN_W = 10
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic             ce_a;
    logic             ce_b;
    logic             ce_m;
    logic             ce_p;
    logic [7:0]       opmode;
    logic             busy;
    logic             done;
    logic             err_len0;

    modport master (
        output start, len, in_valid,
        input  in_ready, ce_a, ce_b, ce_m, ce_p, opmode, busy, done, err_len0
    );

    modport slave (
        input  start, len, in_valid,
        output in_ready, ce_a, ce_b, ce_m, ce_p, opmode, busy, done, err_len0
    );
endinterface

// File: rtl/dsp48a1_valid_pipe.sv
// Shadow of the slice pipeline: tracks which cycles carry a real beat and whether
// that beat is the first of its job, so M/P enables line up with the data.
module dsp48a1_valid_pipe #(
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beat_in,
    input  logic first_in,
    output logic m_valid,
    output logic p_valid,
    output logic p_first,
    output logic head_empty
);

    logic [PIPE_LAT-1:0] vld_q;
    logic [PIPE_LAT-1:0] fst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            fst_q <= '0;
        end else begin
            vld_q <= {vld_q[PIPE_LAT-2:0], beat_in};
            fst_q <= {fst_q[PIPE_LAT-2:0], beat_in & first_in};
        end
    end

    assign m_valid    = vld_q[PIPE_LAT-2];
    assign p_valid    = vld_q[PIPE_LAT-1];
    assign p_first    = fst_q[PIPE_LAT-1];
    // True when the beat at the P tap (if any) is the only one still in flight.
    assign head_empty = ~|vld_q[PIPE_LAT-2:0];

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Sequences one DSP48A1 slice through an N-beat multiply-accumulate job.
//   state | meaning
//   IDLE  | waiting for start; len==0 flags err_len0
//   RUN   | accepting operand beats until len have been taken
//   DRAIN | no new beats; wait for the last one to reach P, then pulse done
module dsp48a1_mac_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int         LEN_W    = 10,
    parameter int         PIPE_LAT = 3,
    parameter logic [7:0] OPM_LOAD = OPM_LOAD_DEF,
    parameter logic [7:0] OPM_ACC  = OPM_ACC_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    dsp48a1_mac_sequencer_if.slave bus
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       opmode_q, opmode_d;

    logic in_ready;
    logic accept;
    logic first_beat;
    logic m_valid;
    logic p_valid;
    logic p_first;
    logic head_empty;

    assign in_ready   = (state_q == ST_RUN) && (cnt_q < len_q);
    assign accept     = bus.in_valid & in_ready;
    assign first_beat = (cnt_q == '0);

    dsp48a1_valid_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_valid_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_in    (accept),
        .first_in   (first_beat),
        .m_valid    (m_valid),
        .p_valid    (p_valid),
        .p_first    (p_first),
        .head_empty (head_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            opmode_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            opmode_q <= opmode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        state_d = ST_RUN;
                        len_d   = bus.len;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == len_q - ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Stay in DRAIN through the done cycle so busy covers it.
                if (done_q) begin
                    state_d = ST_IDLE;
                end else if (p_valid && head_empty) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // OPMODE follows the beat at the P tap and holds through bubbles.
    always_comb begin
        opmode_d = opmode_q;
        if (p_valid) begin
            opmode_d = p_first ? OPM_LOAD : OPM_ACC;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.ce_a     = accept;
    assign bus.ce_b     = accept;
    assign bus.ce_m     = m_valid;
    assign bus.ce_p     = p_valid;
    assign bus.opmode   = opmode_d;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.err_len0 = err_q;

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer: table-driven jobs, a P-register model fed by a
// scoreboard of products, and hand sequences for len==0, DRAIN restarts and reset.
module tb_dsp48a1_mac_sequencer;

    localparam int LEN_W    = 10;
    localparam int PIPE_LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsp48a1_mac_sequencer_if #(.LEN_W(LEN_W)) bus();

    dsp48a1_mac_sequencer #(
        .LEN_W    (LEN_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int              len;
        logic [15:0]     vpat;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        int              exp_sum;
        int              exp_done;
    } vec_t;

    typedef struct {
        int         prod;
        logic [7:0] opm;
        int         cyc;
    } sb_t;

    vec_t vecs[4];
    sb_t  sb[$];
    sb_t  e;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int op_a = 0, op_b = 0;
    int beat_no = 0, ce_p_cnt = 0, load_cnt = 0, any_ce = 0;
    int first_acc = -1, last_acc = -1, done_cyc = -1;
    int slice_p = 0;
    bit done_seen = 1'b0;
    logic prev_ce_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int len, input logic [15:0] vp,
                                input int a0, input int a1, input int a2, input int a3,
                                input int b0, input int b1, input int b2, input int b3,
                                input int sum, input int dn);
        vec_t v;
        v.len      = len;
        v.vpat     = vp;
        v.a        = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        v.b        = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
        v.exp_sum  = sum;
        v.exp_done = dn;
        return v;
    endfunction

    // Monitor: scoreboard push on accept, pop and P-model update on ce_p.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ce_a | bus.ce_m | bus.ce_p) any_ce++;
            if (bus.ce_a) begin
                chk("ce_b_eq_ce_a", bus.ce_b, 1);
                chk("accept_needs_valid", bus.in_valid, 1);
                sb.push_back('{prod: op_a * op_b, opm: (beat_no == 0) ? 8'h01 : 8'h09, cyc: cyc});
                if (beat_no == 0) first_acc = cyc;
                last_acc = cyc;
                beat_no++;
            end
            if (bus.ce_p) begin
                if (sb.size() == 0) begin
                    chk("ce_p_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("opmode", bus.opmode, e.opm);
                    chk("ce_p_latency", cyc - e.cyc, PIPE_LAT);
                    chk("ce_m_before_ce_p", prev_ce_m, 1);
                    if (bus.opmode == 8'h01) begin
                        slice_p = e.prod;
                        load_cnt++;
                    end else if (bus.opmode == 8'h09) begin
                        slice_p = slice_p + e.prod;
                    end
                    ce_p_cnt++;
                end
            end
            if (bus.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                chk("busy_in_done_cycle", bus.busy, 1);
            end
            prev_ce_m = bus.ce_m;
        end
    end

    // Entered and left at posedge+1; returns in the cycle after done.
    task automatic run_job(input int i, input bit inject);
        int k;
        int s;
        beat_no   = 0;
        ce_p_cnt  = 0;
        load_cnt  = 0;
        done_seen = 1'b0;
        first_acc = -1;
        last_acc  = -1;
        s = cyc;
        bus.start = 1'b1;
        bus.len   = LEN_W'(vecs[i].len);
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        while (beat_no < vecs[i].len && k < 16) begin
            bus.in_valid = vecs[i].vpat[k[3:0]];
            op_a = $signed(vecs[i].a[beat_no[1:0]]);
            op_b = $signed(vecs[i].b[beat_no[1:0]]);
            k++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (inject) begin
            bus.start = 1'b1;
            bus.len   = LEN_W'(5);
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        k = 0;
        while (!done_seen && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_seen", done_seen, 1);
        chk("first_accept_cycle", first_acc - s, 1);
        chk("done_cycle", done_cyc - s, vecs[i].exp_done);
        chk("done_after_last_accept", done_cyc - last_acc, PIPE_LAT + 1);
        chk("ce_p_count", ce_p_cnt, vecs[i].len);
        chk("load_count", load_cnt, 1);
        chk("final_p", slice_p, vecs[i].exp_sum);
        chk("scoreboard_empty", sb.size(), 0);
        chk("busy_after_done", bus.busy, 0);
    endtask

    initial begin
        int ce_before;
        vecs[0] = mk(4, 16'hFFFF,   1,  2,  3, 4,    5,  6,  7, 8,    70, 8);
        vecs[1] = mk(3, 16'hFFF9,   3, -2,  5, 0,    4,  7, -1, 0,    -7, 9);
        vecs[2] = mk(1, 16'hFFFF,  -6,  0,  0, 0,    9,  0,  0, 0,   -54, 5);
        vecs[3] = mk(2, 16'hFFFD, 100, -100, 0, 0, 100, 50,  0, 0,  5000, 7);

        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_ce_a", bus.ce_a, 0);
        chk("rst_ce_b", bus.ce_b, 0);
        chk("rst_ce_m", bus.ce_m, 0);
        chk("rst_ce_p", bus.ce_p, 0);
        chk("rst_opmode", bus.opmode, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err_len0", bus.err_len0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // len == 0 request
        ce_before = any_ce;
        bus.start = 1'b1;
        bus.len   = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("err_len0_pulse", bus.err_len0, 1);
        chk("err_len0_busy", bus.busy, 0);
        @(negedge clk);
        chk("err_len0_one_cycle", bus.err_len0, 0);
        chk("err_len0_busy_after", bus.busy, 0);
        chk("err_len0_no_ce", any_ce - ce_before, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            run_job(i, 1'b0);
        end

        // start during DRAIN ignored, then a new job the cycle after done
        run_job(3, 1'b1);
        run_job(0, 1'b0);

        // reset in the middle of RUN
        bus.start = 1'b1;
        bus.len   = LEN_W'(4);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("ce_a_before_reset", bus.ce_a, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_ce_a", bus.ce_a, 0);
        chk("midrst_ce_m", bus.ce_m, 0);
        chk("midrst_ce_p", bus.ce_p, 0);
        chk("midrst_opmode", bus.opmode, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        prev_ce_m = 1'b0;
        @(posedge clk); #1;
        run_job(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
